// File: rtl/sdram_arbiter.sv
// Two-port Avalon-MM arbiter onto one SDRAM master port: round-robin grant, grant lock while
// SDRAM stalls, and an in-order ID FIFO that steers pipelined read data back to its issuer.
module sdram_arbiter #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        m0_waitrequest,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  output logic        m1_waitrequest,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  input  logic        sdram_waitrequest,
  output logic [31:0] sdram_address,
  output logic        sdram_read,
  output logic        sdram_write,
  output logic [31:0] sdram_writedata,
  input  logic [31:0] sdram_readdata,
  input  logic        sdram_readdatavalid,
  output logic        err_orphan
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Handshake: a transfer happens at a rising edge where the requester asserts read/write
  // and sees waitrequest low; while waitrequest is high it holds command, address and data.
  logic          req0, req1;
  logic          grant_v, grant_id;
  logic          sel_read, sel_write;
  logic          fifo_empty, fifo_full;
  logic          pop, push, head_id;
  logic          rd_block, fwd_ok, present, accept;

  logic          lock_v_q, lock_v_d;
  logic          lock_id_q, lock_id_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic [DEPTH-1:0] id_mem_q, id_mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    grant_v  = 1'b0;
    grant_id = 1'b0;
    if (lock_v_q) begin
      grant_v  = 1'b1;
      grant_id = lock_id_q;
    end else if (req0 & req1) begin
      grant_v  = 1'b1;
      grant_id = ~last_q;
    end else if (req0) begin
      grant_v  = 1'b1;
      grant_id = 1'b0;
    end else if (req1) begin
      grant_v  = 1'b1;
      grant_id = 1'b1;
    end
  end

  // A simultaneous read+write is a write; the read strobe is dropped.
  assign sel_write = grant_v & (grant_id ? m1_write : m0_write);
  assign sel_read  = grant_v & ~sel_write & (grant_id ? m1_read : m0_read);

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign pop        = sdram_readdatavalid & ~fifo_empty;
  assign head_id    = id_mem_q[rd_ptr_q];

  // A same-cycle pop frees a slot, so a full FIFO only blocks reads when nothing returns.
  assign rd_block = sel_read & fifo_full & ~pop;
  assign fwd_ok   = rst_n & grant_v & ~sdram_waitrequest & ~rd_block;
  assign present  = rst_n & (sel_write | (sel_read & ~rd_block));
  assign accept   = present & ~sdram_waitrequest;
  assign push     = accept & sel_read;

  assign sdram_read      = rst_n & sel_read & ~rd_block;
  assign sdram_write     = rst_n & sel_write;
  assign sdram_address   = grant_id ? m1_address : m0_address;
  assign sdram_writedata = grant_id ? m1_writedata : m0_writedata;

  assign m0_waitrequest   = ~(fwd_ok & ~grant_id);
  assign m1_waitrequest   = ~(fwd_ok & grant_id);
  assign m0_readdata      = sdram_readdata;
  assign m1_readdata      = sdram_readdata;
  assign m0_readdatavalid = rst_n & pop & ~head_id;
  assign m1_readdatavalid = rst_n & pop & head_id;
  assign err_orphan       = err_q;

  always_comb begin
    // Only a command actually on the SDRAM bus pins the grant; a read held back by a
    // full FIFO never reached SDRAM, so the other requester may still be served.
    lock_v_d  = present & sdram_waitrequest;
    lock_id_d = (present & sdram_waitrequest) ? grant_id : lock_id_q;
    last_d    = accept ? grant_id : last_q;
    err_d     = err_q | (sdram_readdatavalid & fifo_empty);

    id_mem_d = id_mem_q;
    if (push) begin
      id_mem_d[wr_ptr_q] = grant_id;
    end
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    cnt_d = cnt_q;
    if (push & ~pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop & ~push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_v_q  <= 1'b0;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      id_mem_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      lock_v_q  <= lock_v_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      err_q     <= err_d;
      id_mem_q  <= id_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios followed by randomized traffic checked against
// a transaction-level model (expected-ID queue, held-transfer owner, round-robin preference).
module tb_sdram_arbiter;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_address, m1_address;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        sdram_waitrequest;
  logic [31:0] sdram_address;
  logic        sdram_read, sdram_write;
  logic [31:0] sdram_writedata;
  logic [31:0] sdram_readdata;
  logic        sdram_readdatavalid;
  logic        err_orphan;

  sdram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .m0_waitrequest      (m0_waitrequest),
    .m0_address          (m0_address),
    .m0_read             (m0_read),
    .m0_write            (m0_write),
    .m0_writedata        (m0_writedata),
    .m0_readdata         (m0_readdata),
    .m0_readdatavalid    (m0_readdatavalid),
    .m1_waitrequest      (m1_waitrequest),
    .m1_address          (m1_address),
    .m1_read             (m1_read),
    .m1_write            (m1_write),
    .m1_writedata        (m1_writedata),
    .m1_readdata         (m1_readdata),
    .m1_readdatavalid    (m1_readdatavalid),
    .sdram_waitrequest   (sdram_waitrequest),
    .sdram_address       (sdram_address),
    .sdram_read          (sdram_read),
    .sdram_write         (sdram_write),
    .sdram_writedata     (sdram_writedata),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid),
    .err_orphan          (err_orphan)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          model_en = 1'b0;
  int          lat_min  = 3;
  int          lat_max  = 3;
  int          due_q[$];
  logic [31:0] dat_q[$];
  logic [31:0] rd_data_q[$];
  logic [0:0]  exp_q[$];

  // Random-phase reference state
  bit          act   [0:1];
  bit          op_rd [0:1];
  bit          op_wr [0:1];
  logic [31:0] adr   [0:1];
  logic [31:0] wd    [0:1];
  bit          held_v, held_id, last_acc;
  bit          g_v, g, e_rd, e_wr, blocked, acc;
  logic [0:0]  id;
  int          kind;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_writedata = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_writedata = '0;
    sdram_waitrequest = 1'b0;
    sdram_readdatavalid = 1'b0;
    sdram_readdata = '0;
  endtask

  // SDRAM responder: answers reads seen on the bus after a bounded latency, in order.
  task automatic advance();
    if (model_en && sdram_read && !sdram_waitrequest) begin
      int due;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due_q.size() > 0 && due <= due_q[$]) due = due_q[$] + 1;
      due_q.push_back(due);
      dat_q.push_back(rd_data_q.size() > 0 ? rd_data_q.pop_front() : $urandom());
    end
    @(posedge clk);
    #1;
    cyc++;
    sdram_readdatavalid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      sdram_readdatavalid = 1'b1;
      sdram_readdata = dat_q.pop_front();
    end
  endtask

  // Reset is checked while held with requests and a return strobe present.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    m0_write = 1'b1;
    m1_read = 1'b1;
    sdram_readdatavalid = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_sdram_read", sdram_read, 0);
    chk("rst_sdram_write", sdram_write, 0);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    chk("rst_err", err_orphan, 0);
    idle_inputs();
    due_q.delete(); dat_q.delete(); rd_data_q.delete(); exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single write
    do_reset();
    model_en = 1'b0;
    m0_address = 32'h100; m0_writedata = 32'hDEADBEEF; m0_write = 1'b1;
    #3;
    chk("wr_sdram_write", sdram_write, 1);
    chk("wr_sdram_addr", sdram_address, 32'h100);
    chk("wr_sdram_wdata", sdram_writedata, 32'hDEADBEEF);
    chk("wr_m0_wait", m0_waitrequest, 0);
    chk("wr_m1_wait", m1_waitrequest, 1);
    advance();
    m0_write = 1'b0;

    // Contention plus in-order return, latency 3
    do_reset();
    model_en = 1'b1; lat_min = 3; lat_max = 3;
    rd_data_q.push_back(32'hAAAA); rd_data_q.push_back(32'hBBBB);
    m0_address = 32'h10; m0_read = 1'b1;
    m1_address = 32'h20; m1_read = 1'b1;
    #3;
    chk("cont_c0_m0_wait", m0_waitrequest, 0);
    chk("cont_c0_m1_wait", m1_waitrequest, 1);
    chk("cont_c0_addr", sdram_address, 32'h10);
    chk("cont_c0_read", sdram_read, 1);
    advance();
    m0_read = 1'b0;
    #3;
    chk("cont_c1_m1_wait", m1_waitrequest, 0);
    chk("cont_c1_addr", sdram_address, 32'h20);
    advance();
    m1_read = 1'b0;
    #3;
    chk("cont_c2_m0_rdv", m0_readdatavalid, 0);
    chk("cont_c2_m1_rdv", m1_readdatavalid, 0);
    advance();
    #3;
    chk("cont_c3_m0_rdv", m0_readdatavalid, 1);
    chk("cont_c3_m1_rdv", m1_readdatavalid, 0);
    chk("cont_c3_m0_data", m0_readdata, 32'hAAAA);
    advance();
    #3;
    chk("cont_c4_m0_rdv", m0_readdatavalid, 0);
    chk("cont_c4_m1_rdv", m1_readdatavalid, 1);
    chk("cont_c4_m1_data", m1_readdata, 32'hBBBB);
    advance();
    #3;
    chk("cont_c5_m0_rdv", m0_readdatavalid, 0);
    chk("cont_c5_m1_rdv", m1_readdatavalid, 0);
    advance();

    // Lock under stall: m0 write stalled 4 cycles, m1 reading throughout
    do_reset();
    model_en = 1'b0;
    m0_address = 32'h300; m0_writedata = 32'h33; m0_write = 1'b1;
    m1_address = 32'h400; m1_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sdram_waitrequest = (k < 4);
      #3;
      chk($sformatf("lock_addr_%0d", k), sdram_address, 32'h300);
      chk($sformatf("lock_m1_wait_%0d", k), m1_waitrequest, 1);
      chk($sformatf("lock_m0_wait_%0d", k), m0_waitrequest, (k < 4) ? 1 : 0);
      advance();
    end
    m0_write = 1'b0;
    sdram_waitrequest = 1'b0;
    #3;
    chk("lock_m1_accept", m1_waitrequest, 0);
    chk("lock_m1_addr", sdram_address, 32'h400);
    chk("lock_m1_read", sdram_read, 1);
    advance();
    m1_read = 1'b0;

    // Lock where round-robin alone would hand the grant to m1 mid-stall
    do_reset();
    m0_address = 32'h500; m0_read = 1'b1;
    #3;
    advance();
    m0_read = 1'b0;
    m0_address = 32'h600; m0_write = 1'b1; sdram_waitrequest = 1'b1;
    #3;
    chk("lock2_a_addr", sdram_address, 32'h600);
    advance();
    m1_address = 32'h700; m1_read = 1'b1;
    #3;
    chk("lock2_b_addr", sdram_address, 32'h600);
    chk("lock2_b_write", sdram_write, 1);
    chk("lock2_b_m1_wait", m1_waitrequest, 1);
    advance();
    sdram_waitrequest = 1'b0;
    #3;
    chk("lock2_c_addr", sdram_address, 32'h600);
    chk("lock2_c_m0_wait", m0_waitrequest, 0);
    advance();
    m0_write = 1'b0;
    #3;
    chk("lock2_d_m1_wait", m1_waitrequest, 0);
    chk("lock2_d_addr", sdram_address, 32'h700);
    advance();
    m1_read = 1'b0;

    // FIFO full
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      m0_address = 32'(k * 4); m0_read = 1'b1;
      #3;
      chk($sformatf("full_fill_%0d", k), m0_waitrequest, 0);
      advance();
    end
    #3;
    chk("full_9th_wait", m0_waitrequest, 1);
    chk("full_9th_read", sdram_read, 0);
    advance();
    m1_address = 32'h900; m1_writedata = 32'h99; m1_write = 1'b1;
    #3;
    chk("full_m1_wait", m1_waitrequest, 0);
    chk("full_m1_write", sdram_write, 1);
    chk("full_m1_addr", sdram_address, 32'h900);
    chk("full_m0_still_wait", m0_waitrequest, 1);
    advance();
    m1_write = 1'b0;
    sdram_readdatavalid = 1'b1; sdram_readdata = 32'h1234;
    #3;
    chk("full_pop_m0_wait", m0_waitrequest, 0);
    chk("full_pop_read", sdram_read, 1);
    chk("full_pop_m0_rdv", m0_readdatavalid, 1);
    chk("full_pop_m1_rdv", m1_readdatavalid, 0);
    advance();
    m0_read = 1'b0;

    // Orphan return
    do_reset();
    sdram_readdatavalid = 1'b1; sdram_readdata = 32'h5555;
    #3;
    chk("orph_m0_rdv", m0_readdatavalid, 0);
    chk("orph_m1_rdv", m1_readdatavalid, 0);
    chk("orph_err_before", err_orphan, 0);
    advance();
    #3;
    chk("orph_err_rise", err_orphan, 1);
    advance();
    #3;
    chk("orph_err_sticky", err_orphan, 1);
    advance();

    // Reset mid-stream with 3 reads outstanding
    do_reset();
    for (int k = 0; k < 3; k++) begin
      m0_address = 32'h800 + 32'(k); m0_read = 1'b1;
      #3;
      advance();
    end
    m0_read = 1'b0;
    m0_address = 32'hA00; m0_write = 1'b1;
    #1;
    chk("mid_pre_m0_wait", m0_waitrequest, 0);
    chk("mid_pre_write", sdram_write, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m0_wait", m0_waitrequest, 1);
    chk("mid_rst_m1_wait", m1_waitrequest, 1);
    chk("mid_rst_write", sdram_write, 0);
    #1;
    rst_n = 1'b1;
    m0_write = 1'b0;
    sdram_readdatavalid = 1'b1;
    #1;
    chk("mid_ret_m0_rdv", m0_readdatavalid, 0);
    chk("mid_ret_m1_rdv", m1_readdatavalid, 0);
    advance();
    m0_read = 1'b1; m1_read = 1'b1;
    m0_address = 32'hB00; m1_address = 32'hC00;
    #3;
    chk("mid_err", err_orphan, 1);
    chk("mid_tie_m0_wait", m0_waitrequest, 0);
    chk("mid_tie_m1_wait", m1_waitrequest, 1);
    advance();
    idle_inputs();

    // Randomized traffic against the transaction-level model
    do_reset();
    model_en = 1'b1; lat_min = 1; lat_max = 12;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; op_rd[i] = 1'b0; op_wr[i] = 1'b0; adr[i] = '0; wd[i] = '0;
    end
    held_v = 1'b0; held_id = 1'b0; last_acc = 1'b1;
    for (int k = 0; k < 700; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && k < 650 && $urandom_range(0, 2) != 0) begin
          act[i] = 1'b1;
          kind = $urandom_range(0, 3);
          op_rd[i] = (kind != 2);
          op_wr[i] = (kind >= 2);
          adr[i] = $urandom();
          wd[i] = $urandom();
        end
      end
      m0_read = act[0] & op_rd[0]; m0_write = act[0] & op_wr[0];
      m0_address = adr[0]; m0_writedata = wd[0];
      m1_read = act[1] & op_rd[1]; m1_write = act[1] & op_wr[1];
      m1_address = adr[1]; m1_writedata = wd[1];
      sdram_waitrequest = ($urandom_range(0, 3) == 0);
      #3;
      g_v = held_v | act[0] | act[1];
      g = held_v ? held_id : ((act[0] & act[1]) ? ~last_acc : act[1]);
      e_wr = g_v & act[g] & op_wr[g];
      e_rd = g_v & act[g] & op_rd[g] & ~op_wr[g];
      blocked = e_rd && (exp_q.size() == DEPTH) && !sdram_readdatavalid;
      acc = (e_wr | (e_rd & ~blocked)) & ~sdram_waitrequest;
      chk("rnd_read", sdram_read, e_rd & ~blocked);
      chk("rnd_write", sdram_write, e_wr);
      if (e_rd | e_wr) chk("rnd_addr", sdram_address, adr[g]);
      if (e_wr) chk("rnd_wdata", sdram_writedata, wd[g]);
      chk("rnd_m0_wait", m0_waitrequest, !(g_v && g == 1'b0 && !sdram_waitrequest && !blocked));
      chk("rnd_m1_wait", m1_waitrequest, !(g_v && g == 1'b1 && !sdram_waitrequest && !blocked));
      if (sdram_readdatavalid && exp_q.size() > 0) begin
        id = exp_q.pop_front();
        chk("rnd_m0_rdv", m0_readdatavalid, (id == 1'b0));
        chk("rnd_m1_rdv", m1_readdatavalid, (id == 1'b1));
        if (id == 1'b0) chk("rnd_m0_data", m0_readdata, sdram_readdata);
        else chk("rnd_m1_data", m1_readdata, sdram_readdata);
      end else begin
        chk("rnd_m0_rdv_idle", m0_readdatavalid, 0);
        chk("rnd_m1_rdv_idle", m1_readdatavalid, 0);
      end
      chk("rnd_err", err_orphan, 0);
      if (acc) begin
        if (e_rd) exp_q.push_back(g);
        act[g] = 1'b0;
        last_acc = g;
      end
      held_v = (e_wr | (e_rd & ~blocked)) & sdram_waitrequest;
      held_id = g;
      advance();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port Avalon-MM arbiter that shares the single SDRAM master port between two requesters, e.g. the `wordcopy` copy engine and the accelerator datapath. Each requester sees a private Avalon master-facing slave port. The arbiter forwards one request per cycle to SDRAM and locks the grant while SDRAM stalls. It returns pipelined read data to the requester that issued each read, using an in-order ID FIFO.

## Interface

Parameters:
- `DEPTH`, default 8: maximum outstanding reads (ID FIFO entries); power of two, ≥2.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `m0_waitrequest` / `m1_waitrequest` out 1: stall to requester i.
- `m0_address` / `m1_address` in 32: byte address from requester i.
- `m0_read` / `m1_read` in 1: read request.
- `m0_write` / `m1_write` in 1: write request.
- `m0_writedata` / `m1_writedata` in 32: write data.
- `m0_readdata` / `m1_readdata` out 32: both driven directly from `sdram_readdata`.
- `m0_readdatavalid` / `m1_readdatavalid` out 1: read return strobe to requester i.
- `sdram_waitrequest` in 1: SDRAM stall.
- `sdram_address` out 32: forwarded address.
- `sdram_read` out 1: forwarded read.
- `sdram_write` out 1: forwarded write.
- `sdram_writedata` out 32: forwarded write data.
- `sdram_readdata` in 32: read return data.
- `sdram_readdatavalid` in 1: read return strobe.
- `err_orphan` out 1: sticky flag; `sdram_readdatavalid` seen with ID FIFO empty.

## Operation

- Request of i: `req_i = mi_read | mi_write`. If both are asserted, the request is treated as a write and the read is ignored.
- State:
  - `lock_v`/`lock_id`: grant held while stalled.
  - `last`: last accepted requester.
  - ID FIFO: 1-bit entries, `DEPTH` deep, plus count.
  - `err_orphan`.
- Grant (combinational):
  - If `lock_v`, the grant is `lock_id`.
  - Otherwise, if exactly one requester has a request, it wins.
  - If both have requests, `~last` wins (round-robin).
  - If neither has a request, there is no grant.
- Forwarding:
  - The granted requester's address, writedata, read and write drive the `sdram_*` outputs.
  - `sdram_read` is forced to 0 while the FIFO is full.
  - With no grant, `sdram_read`/`sdram_write` are 0 and `sdram_address`/`sdram_writedata` are don't-care.
- Requester stall: `mi_waitrequest = ~(grant==i & ~sdram_waitrequest & ~(granted read & fifo_full))`. A non-granted requester always sees 1.
- Accept: the granted request is not stalled this cycle. At the clock edge:
  - `last <= grant`.
  - `lock_v <= 0`.
  - If it was a read, push the grant ID into the FIFO.
- Stall: a granted request that is not accepted sets `lock_v <= 1` and `lock_id <= grant`. Arbitration cannot switch mid-transfer.
- Read return: on `sdram_readdatavalid`, pop the FIFO head and assert `m<head>_readdatavalid` in the same cycle.
  - If the FIFO is empty, discard the return, set `err_orphan <= 1`, and assert neither requester valid.
- Push and pop in the same cycle are allowed: count is unchanged. A pop frees its slot the same cycle, so a read blocked on full may be accepted in that cycle.
- Writes are never blocked by FIFO full.

## Timing

- Zero-cycle forwarding: an unstalled request is accepted in the same cycle it is presented.
- Full throughput: one transfer per cycle. Two requesters alternate on back-to-back contention.
- Read return latency is SDRAM latency plus 0 cycles. Returns are strictly in issue order.
- Reset (async assert):
  - `lock_v=0`, `last=1` so m0 wins the first tie.
  - FIFO empty, `err_orphan=0`.
  - While reset is asserted: `sdram_read=sdram_write=0`, `m*_waitrequest=1`, `m*_readdatavalid=0`.
- Reset mid-operation: outstanding read IDs are lost. Any later `sdram_readdatavalid` sets `err_orphan`. SDRAM must be quiesced by the system.
- `err_orphan` is cleared only by reset.

## Test plan

- **Single write.** After reset, m0 writes addr 0x100, data 0xDEADBEEF, with `sdram_waitrequest=0`. Required in the same cycle: `sdram_write=1`, `sdram_address=0x100`, `sdram_writedata=0xDEADBEEF`, `m0_waitrequest=0`, `m1_waitrequest=1`.
- **Contention plus in-order return.** Both requesters read after reset (m0 0x10, m1 0x20) and hold their requests. The SDRAM model uses latency 3 and returns 0xAAAA then 0xBBBB.
  - Required: m0 accepted in cycle 0, m1 in cycle 1.
  - `m0_readdatavalid` pulses with 0xAAAA, then `m1_readdatavalid` with 0xBBBB.
  - The other requester's valid stays 0 during each pulse.
- **Lock under stall.** m0 writes while `sdram_waitrequest=1` for 4 cycles, and m1 reads throughout.
  - Required: `sdram_address` stays m0's for all 5 cycles and `m1_waitrequest=1`.
  - m1 is accepted on the cycle after m0's acceptance.
- **FIFO full.** With `DEPTH=8`, m0 issues 8 reads with no returns. The 9th m0 read is held with `sdram_read=0` and `m0_waitrequest=1`. An m1 write issued during this window is accepted. One `sdram_readdatavalid` lets the 9th read be accepted in that same cycle.
- **Orphan return.** `sdram_readdatavalid=1` with the FIFO empty: `err_orphan` rises next cycle and stays 1, and neither `m*_readdatavalid` asserts.
- **Reset mid-stream.** With 3 reads outstanding, pulse `rst_n` low asynchronously between edges.
  - Required: waitrequests go to 1 immediately, then FIFO empty and `last=1`.
  - A following simultaneous request is won by m0.
